fifo_burst_writer: RTL and testbench
====================================

# fifo_burst_writer

Write-domain producer for the async FIFO: accepts an upstream valid/ready data stream, issues `W_INC`/`W_DATA` into the FIFO write port, and guarantees that a commanded burst is only started when enough free space exists to complete it without stalling. It runs entirely in the `W_CLK` domain. It owns the 2-flop synchronizer for the read-domain Gray read pointer and feeds the synchronized pointer to the FIFO write-pointer logic.

## Interface
- `DATA_WIDTH`, 8, data word width
- `ADDR_SIZE`, 3, FIFO address bits; DEPTH = 2^ADDR_SIZE, PTR_SIZE = ADDR_SIZE+1
- `W_CLK`  in  1  write-domain clock
- `W_RST`  in  1  asynchronous, active-low reset
- `BURST_START`  in  1  one-cycle command strobe; sampled only in IDLE
- `BURST_LEN`  in  PTR_SIZE  words in burst; legal 1..DEPTH
- `S_DATA`  in  DATA_WIDTH  upstream data
- `S_VALID`  in  1  upstream data valid
- `S_READY`  out  1  upstream accept; transfer = S_VALID & S_READY
- `Gray_ASYNC_RD_PTR`  in  PTR_SIZE  Gray read pointer from the read domain, unsynchronized
- `W_full`  in  1  FIFO full flag from the write-pointer logic
- `Gray_SYNC_RD_PTR`  out  PTR_SIZE  2-flop synchronized Gray read pointer
- `W_INC`  out  1  FIFO write strobe (registered)
- `W_DATA`  out  DATA_WIDTH  FIFO write data (registered)
- `FREE_SPACE`  out  PTR_SIZE  free entries, 0..DEPTH
- `BUSY`  out  1  state != IDLE
- `DONE`  out  1  one-cycle pulse after the last word of a burst is written
- `LEN_ERR`  out  1  one-cycle pulse: illegal BURST_LEN rejected
- `OVF_ERR`  out  1  sticky: W_INC issued while W_full=1; cleared only by reset

## Operation
- Synchronizer: two flops on `Gray_ASYNC_RD_PTR`, reset 0; second stage drives `Gray_SYNC_RD_PTR`.
- Gray→binary conversion of the synchronized pointer gives `rptr_b`. Shadow binary write pointer `wptr_b` (PTR_SIZE) increments on every cycle `W_INC`=1 and wraps modulo 2^PTR_SIZE.
- FREE_SPACE = DEPTH − ((wptr_b − rptr_b) mod 2^PTR_SIZE). The value is combinational from registers and conservative: it is stale by the synchronizer delay and never overstates space.
- FSM states:
  - IDLE: `BURST_START`=1 with BURST_LEN in 1..DEPTH latches `len_q` and `remaining`=BURST_LEN, then goes to WAIT. With BURST_LEN=0 or >DEPTH: pulse LEN_ERR, stay in IDLE.
  - WAIT: if FREE_SPACE ≥ `len_q` (checked every cycle), go to BURST.
  - BURST: S_READY = ~W_full. Each transfer registers S_DATA into W_DATA, asserts W_INC the next cycle, and decrements `remaining`. When the transfer with `remaining`=1 occurs, go to DRAIN.
  - DRAIN: one cycle to flush the final W_INC, pulse DONE, then return to IDLE.
- S_READY=0 outside BURST. BURST_START outside IDLE is ignored.
- Upstream may drop S_VALID mid-burst: the FSM holds in BURST with W_INC=0 until the remaining words arrive.
- Because space was reserved, W_full should never be seen during BURST. If W_INC=1 and W_full=1 in the same cycle, OVF_ERR is set.

## Timing
- Reset (asynchronous, immediate): state=IDLE; S_READY, W_INC, DONE, LEN_ERR, OVF_ERR, BUSY = 0; W_DATA=0; sync flops, wptr_b, rptr_b = 0; FREE_SPACE=DEPTH. Reset mid-burst abandons the burst; no further W_INC is issued.
- BURST_START at edge n: BUSY=1 from n+1 (WAIT). If space suffices, BURST from n+2, so S_READY is first high in cycle n+2.
- Transfer at edge k → W_INC=1 and W_DATA valid during cycle k+1 → wptr_b updates at edge k+2.
- Full-rate burst of L words: L consecutive W_INC cycles. DONE is high in the cycle after the last W_INC. A new BURST_START is accepted the cycle DONE is high.
- Read-pointer change → visible in FREE_SPACE after 2 W_CLK edges.
- Wrap-around: pointers wrap at 2^PTR_SIZE. Subtraction is done modulo PTR_SIZE bits; FREE_SPACE stays correct across the wrap.

## Test plan
- Reset, empty FIFO (read ptr 0), BURST_LEN=8, S_VALID held high with data 0x10..0x17 → 8 consecutive W_INC with W_DATA 0x10..0x17, FREE_SPACE 8→0, DONE pulse, no OVF_ERR.
- FIFO holds 6 (FREE_SPACE=2), BURST_LEN=4 → stays in WAIT, S_READY=0. Read domain advances Gray pointer by 2 → two cycles later FREE_SPACE=4 → BURST starts and writes 4 words.
- BURST_LEN=0, then BURST_LEN=9 (DEPTH=8) → LEN_ERR pulses each time, BUSY stays 0, no W_INC.
- BURST_LEN=5 with S_VALID toggling 1,0,0,1… → exactly 5 W_INC issued, data in order, BUSY held until DONE.
- Run 20 bursts of length 3 with the reader draining → pointers wrap past 15→0; FREE_SPACE never exceeds 8 or goes negative; data order preserved.
- Force W_full=1 during BURST → S_READY=0, OVF_ERR stays 0. Assert W_RST low mid-burst → W_INC, S_READY, BUSY = 0 immediately; FREE_SPACE=8 after release.

Source files
------------

// File: rtl/fifo_burst_writer.sv
// Write-domain producer for the async FIFO: reserves FIFO space for a whole burst
// before accepting upstream words, then streams them into the FIFO write port.
module fifo_burst_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 3
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  BURST_START,
  input  logic [ADDR_SIZE:0]    BURST_LEN,
  input  logic [DATA_WIDTH-1:0] S_DATA,
  input  logic                  S_VALID,
  output logic                  S_READY,
  input  logic [ADDR_SIZE:0]    Gray_ASYNC_RD_PTR,
  input  logic                  W_full,
  output logic [ADDR_SIZE:0]    Gray_SYNC_RD_PTR,
  output logic                  W_INC,
  output logic [DATA_WIDTH-1:0] W_DATA,
  output logic [ADDR_SIZE:0]    FREE_SPACE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  LEN_ERR,
  output logic                  OVF_ERR
);

  localparam int PTR_SIZE = ADDR_SIZE + 1;
  localparam logic [ADDR_SIZE:0] DEPTH = {1'b1, {ADDR_SIZE{1'b0}}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] BURST = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [ADDR_SIZE:0]    sync1_reg, sync2_reg;
  logic [ADDR_SIZE:0]    wptr_b_reg;
  logic [ADDR_SIZE:0]    rptr_b;
  logic [ADDR_SIZE:0]    len_q_reg, remaining_reg;
  logic                  w_inc_reg;
  logic [DATA_WIDTH-1:0] w_data_reg;
  logic                  done_reg, len_err_reg, ovf_err_reg;
  logic                  len_ok, start_ok, xfer, s_ready;
  logic [ADDR_SIZE:0]    free_space;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  genvar gi;
  generate
    for (gi = 0; gi < PTR_SIZE; gi++) begin : g_gray2bin
      assign rptr_b[gi] = ^sync2_reg[ADDR_SIZE:gi];
    end
  endgenerate

  // Modulo subtraction keeps this correct across pointer wrap; the stale read
  // pointer can only make it under-report space.
  assign free_space = DEPTH - (wptr_b_reg - rptr_b);

  assign len_ok   = (BURST_LEN != '0) && (BURST_LEN <= DEPTH);
  assign start_ok = (state_reg == IDLE) && BURST_START && len_ok;
  assign s_ready  = (state_reg == BURST) && !W_full;
  assign xfer     = S_VALID && s_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = WAIT;
      WAIT:    if (free_space >= len_q_reg) state_next = BURST;
      BURST:   if (xfer && (remaining_reg == {{ADDR_SIZE{1'b0}}, 1'b1})) state_next = DRAIN;
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      state_reg     <= IDLE;
      sync1_reg     <= '0;
      sync2_reg     <= '0;
      wptr_b_reg    <= '0;
      len_q_reg     <= '0;
      remaining_reg <= '0;
    end else begin
      state_reg  <= state_next;
      sync1_reg  <= Gray_ASYNC_RD_PTR;
      sync2_reg  <= sync1_reg;
      wptr_b_reg <= wptr_b_reg + {{ADDR_SIZE{1'b0}}, w_inc_reg};
      if (start_ok) begin
        len_q_reg     <= BURST_LEN;
        remaining_reg <= BURST_LEN;
      end else if (xfer) begin
        remaining_reg <= remaining_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      w_inc_reg   <= 1'b0;
      w_data_reg  <= '0;
      done_reg    <= 1'b0;
      len_err_reg <= 1'b0;
      ovf_err_reg <= 1'b0;
    end else begin
      w_inc_reg   <= xfer;
      if (xfer) w_data_reg <= S_DATA;
      done_reg    <= (state_reg == DRAIN);
      len_err_reg <= (state_reg == IDLE) && BURST_START && !len_ok;
      ovf_err_reg <= ovf_err_reg || (w_inc_reg && W_full);
    end
  end

  assign S_READY          = s_ready;
  assign Gray_SYNC_RD_PTR = sync2_reg;
  assign W_INC            = w_inc_reg;
  assign W_DATA           = w_data_reg;
  assign FREE_SPACE       = free_space;
  assign BUSY             = (state_reg != IDLE);
  assign DONE             = done_reg;
  assign LEN_ERR          = len_err_reg;
  assign OVF_ERR          = ovf_err_reg;

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Scoreboard bench for fifo_burst_writer: burst data is queued as expected output
// when issued, and a monitor pops it on every FIFO write.
module tb_fifo_burst_writer;

  logic       W_CLK = 1'b0;
  logic       W_RST;
  logic       BURST_START;
  logic [3:0] BURST_LEN;
  logic [7:0] S_DATA;
  logic       S_VALID;
  logic       S_READY;
  logic [3:0] Gray_ASYNC_RD_PTR;
  logic       W_full;
  logic [3:0] Gray_SYNC_RD_PTR;
  logic       W_INC;
  logic [7:0] W_DATA;
  logic [3:0] FREE_SPACE;
  logic       BUSY, DONE, LEN_ERR, OVF_ERR;

  fifo_burst_writer #(.DATA_WIDTH(8), .ADDR_SIZE(3)) dut (
    .W_CLK(W_CLK), .W_RST(W_RST), .BURST_START(BURST_START), .BURST_LEN(BURST_LEN),
    .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .Gray_ASYNC_RD_PTR(Gray_ASYNC_RD_PTR), .W_full(W_full),
    .Gray_SYNC_RD_PTR(Gray_SYNC_RD_PTR), .W_INC(W_INC), .W_DATA(W_DATA),
    .FREE_SPACE(FREE_SPACE), .BUSY(BUSY), .DONE(DONE), .LEN_ERR(LEN_ERR), .OVF_ERR(OVF_ERR)
  );

  always #5 W_CLK = ~W_CLK;

  int errors = 0;
  int checks = 0;

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  int  wr_total = 0;
  int  rd_total = 0;
  int  rd_target = 0;
  bit  rd_auto = 0;
  bit  force_full = 0;
  int  valid_mode = 0;
  int  winc_cnt = 0;
  int  done_cnt = 0;
  int  lenerr_cnt = 0;
  logic [3:0] rd_bin;

  // Reader-side model of the FIFO: the reader pointer in Gray code and a true full flag
  assign rd_bin = 4'(rd_total);
  assign Gray_ASYNC_RD_PTR = rd_bin ^ (rd_bin >> 1);
  assign W_full = force_full || ((wr_total - rd_total) >= 8);

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(negedge W_CLK);
    #3;
  endtask

  // Monitor: pops the scoreboard on each write and checks free-space bounds
  initial begin : monitor
    bit inc_prev, done_prev, old_inc;
    int occ;
    inc_prev = 0;
    done_prev = 0;
    forever begin
      @(negedge W_CLK);
      if (!W_RST) begin
        exp_q.delete();
        wr_total = 0;
        inc_prev = 0;
        done_prev = 0;
      end else begin
        old_inc = inc_prev;
        wr_total += int'(old_inc);
        inc_prev = W_INC;
        if (W_INC) begin
          winc_cnt++;
          if (exp_q.size() == 0) chk("unexpected_winc", 1, 0);
          else chk("wdata", int'(W_DATA), int'(exp_q.pop_front()));
        end
        if (DONE) begin
          done_cnt++;
          chk("done_after_last_winc", int'(old_inc), 1);
          chk("done_one_cycle", int'(done_prev), 0);
        end
        done_prev = DONE;
        if (LEN_ERR) lenerr_cnt++;
        occ = wr_total - rd_total;
        chk("free_bound", int'((int'(FREE_SPACE) <= 8) && (int'(FREE_SPACE) <= 8 - occ)), 1);
      end
    end
  end

  // Upstream source: offers the head of src_q according to valid_mode
  initial begin : feeder
    bit xfer_pending, v;
    int vpat;
    xfer_pending = 0;
    vpat = 0;
    S_VALID = 0;
    S_DATA = 0;
    forever begin
      @(negedge W_CLK);
      if (!W_RST) begin
        src_q.delete();
        xfer_pending = 0;
        S_VALID = 0;
      end else begin
        if (xfer_pending && src_q.size() > 0) void'(src_q.pop_front());
        case (valid_mode)
          0:       v = 1;
          1:       v = 1'($urandom_range(0, 1));
          2:       v = ((vpat % 3) == 0);
          default: v = 0;
        endcase
        vpat++;
        if (v && src_q.size() > 0) begin
          S_VALID = 1;
          S_DATA = src_q[0];
        end else begin
          S_VALID = 0;
          S_DATA = 8'($urandom);
        end
        #4;
        xfer_pending = S_VALID && S_READY && W_RST;
      end
    end
  end

  initial begin : reader
    forever begin
      @(negedge W_CLK);
      if (!W_RST) rd_total = 0;
      else if (rd_auto) begin
        if ((wr_total - rd_total) > 0 && $urandom_range(0, 1) == 1) rd_total++;
      end else rd_total = rd_target;
    end
  end

  task automatic issue(input int len, input int base);
    if (len >= 1 && len <= 8) begin
      for (int i = 0; i < len; i++) begin
        logic [7:0] d;
        d = (base >= 0) ? 8'(base + i) : 8'($urandom);
        src_q.push_back(d);
        exp_q.push_back(d);
      end
    end
    BURST_START = 1;
    BURST_LEN = 4'(len);
    step();
    BURST_START = 0;
  endtask

  task automatic wait_done(input int budget, output int max_run, output bit busy_ok);
    int run;
    bit got;
    run = 0; max_run = 0; busy_ok = 1; got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (DONE) got = 1;
      else begin
        if (!BUSY) busy_ok = 0;
        run = W_INC ? run + 1 : 0;
        if (run > max_run) max_run = run;
      end
    end
    chk("done_seen", int'(got), 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w0, mr, ok;
    bit bok, seen;
    W_RST = 0;
    BURST_START = 0;
    BURST_LEN = 0;
    repeat (3) step();
    chk("rst_s_ready", int'(S_READY), 0);
    chk("rst_w_inc", int'(W_INC), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_len_err", int'(LEN_ERR), 0);
    chk("rst_ovf", int'(OVF_ERR), 0);
    chk("rst_w_data", int'(W_DATA), 0);
    chk("rst_free", int'(FREE_SPACE), 8);
    chk("rst_sync_ptr", int'(Gray_SYNC_RD_PTR), 0);
    W_RST = 1;
    repeat (2) step();

    // Full-rate burst of 8 into an empty FIFO
    w0 = winc_cnt;
    chk("t1_free_before", int'(FREE_SPACE), 8);
    issue(8, 16);
    chk("t1_busy_n1", int'(BUSY), 1);
    chk("t1_ready_n1", int'(S_READY), 0);
    step();
    chk("t1_ready_n2", int'(S_READY), 1);
    wait_done(60, mr, bok);
    chk("t1_winc_count", winc_cnt - w0, 8);
    chk("t1_consecutive", mr, 8);
    chk("t1_free_after", int'(FREE_SPACE), 0);
    chk("t1_ovf", int'(OVF_ERR), 0);
    chk("t1_sb_empty", exp_q.size(), 0);

    // FIFO holds 6; a burst of 4 must wait for the reader
    rd_target = 2;
    repeat (4) step();
    chk("t2_free_2", int'(FREE_SPACE), 2);
    w0 = winc_cnt;
    issue(4, -1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_wait_ready", int'(S_READY), 0);
      chk("t2_wait_busy", int'(BUSY), 1);
    end
    rd_target = 4;
    step();
    step();
    chk("t2_free_one_edge", int'(FREE_SPACE), 2);
    step();
    chk("t2_free_two_edges", int'(FREE_SPACE), 4);
    chk("t2_still_wait", int'(S_READY), 0);
    step();
    chk("t2_burst_ready", int'(S_READY), 1);
    wait_done(60, mr, bok);
    chk("t2_winc_count", winc_cnt - w0, 4);
    chk("t2_sb_empty", exp_q.size(), 0);
    rd_target = wr_total;
    repeat (4) step();
    chk("t2_free_drained", int'(FREE_SPACE), 8);

    // Illegal lengths
    w0 = winc_cnt;
    ok = lenerr_cnt;
    issue(0, -1);
    chk("t3_len0_err", int'(LEN_ERR), 1);
    chk("t3_len0_busy", int'(BUSY), 0);
    step();
    chk("t3_len0_pulse", int'(LEN_ERR), 0);
    issue(9, -1);
    chk("t3_len9_err", int'(LEN_ERR), 1);
    chk("t3_len9_busy", int'(BUSY), 0);
    repeat (3) step();
    chk("t3_lenerr_count", lenerr_cnt - ok, 2);
    chk("t3_no_winc", winc_cnt - w0, 0);

    // Gapped upstream 1,0,0,...
    valid_mode = 2;
    w0 = winc_cnt;
    issue(5, -1);
    wait_done(100, mr, bok);
    chk("t4_winc_count", winc_cnt - w0, 5);
    chk("t4_busy_held", int'(bok), 1);
    chk("t4_sb_empty", exp_q.size(), 0);
    rd_target = wr_total;
    repeat (4) step();

    // 20 bursts of 3 with a random reader; pointers wrap several times
    valid_mode = 1;
    rd_auto = 1;
    for (int b = 0; b < 20; b++) begin
      w0 = winc_cnt;
      issue(3, -1);
      wait_done(400, mr, bok);
      chk("t5_burst_len", winc_cnt - w0, 3);
    end
    chk("t5_sb_empty", exp_q.size(), 0);
    rd_auto = 0;
    rd_target = wr_total;
    repeat (5) step();
    chk("t5_free_drained", int'(FREE_SPACE), 8);
    chk("t5_ovf", int'(OVF_ERR), 0);

    // Forced full during BURST, overflow detection, then reset mid-burst
    valid_mode = 3;
    issue(6, -1);
    repeat (2) step();
    force_full = 1;
    step();
    chk("t6_full_ready", int'(S_READY), 0);
    valid_mode = 0;
    w0 = winc_cnt;
    repeat (3) begin
      step();
      chk("t6_full_ready_v", int'(S_READY), 0);
    end
    chk("t6_full_no_winc", winc_cnt - w0, 0);
    chk("t6_ovf_clear", int'(OVF_ERR), 0);
    force_full = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (W_INC) seen = 1;
    end
    chk("t6_winc_resumed", int'(seen), 1);
    force_full = 1;
    step();
    force_full = 0;
    chk("t6_ovf_set", int'(OVF_ERR), 1);
    step();
    chk("t6_ovf_sticky", int'(OVF_ERR), 1);
    chk("t6_busy_mid", int'(BUSY), 1);
    rd_target = 0;
    W_RST = 0;
    #1;
    chk("t6_rst_winc", int'(W_INC), 0);
    chk("t6_rst_ready", int'(S_READY), 0);
    chk("t6_rst_busy", int'(BUSY), 0);
    chk("t6_rst_ovf", int'(OVF_ERR), 0);
    repeat (2) step();
    W_RST = 1;
    w0 = winc_cnt;
    repeat (4) step();
    chk("t6_free_after_rst", int'(FREE_SPACE), 8);
    chk("t6_no_winc_after_rst", winc_cnt - w0, 0);
    chk("t6_busy_after_rst", int'(BUSY), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
